// File: rtl/adc_pkg.sv
// Shared definitions for the AD7606 scan scheduler: state encoding,
// default timing constants and the ADC sample width.
package adc_pkg;

  localparam int DEF_CLK_DIV      = 5000;
  localparam int DEF_NUM_CH       = 8;
  localparam int DEF_CONV_PULSE   = 2;
  localparam int DEF_BUSY_TIMEOUT = 1000;
  localparam int ADC_DW           = 16;
  localparam int CH_IDX_W         = 3;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT_BH,
    WAIT_BL,
    ISSUE,
    WAIT_RD,
    NEXT
  } scan_state_t;

endpackage

// File: rtl/adc_rate_timer.sv
// Sample-period timer: counts 0..CLK_DIV-1 while enabled and emits a
// one-cycle tick on the last count. Held at zero while disabled so the
// first tick lands a full period after enable rises.
module adc_rate_timer
  import adc_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  // Period counter, wraps at CLK_DIV-1 and parks at zero when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel scan sequencer for the AD7606: pulses CONVST,
// waits out the chip's BUSY, then issues one read-controller start per
// channel and presents each result with its channel index.
// Optional build macro ADC_SCAN_CH_MASK_EN adds a per-channel mask input
// that suppresses ch_valid for masked channels (all channels still read).
module adc_scan_scheduler
  import adc_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CONV_PULSE   = DEF_CONV_PULSE,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                single_shot,
  input  logic                err_clr,
`ifdef ADC_SCAN_CH_MASK_EN
  input  logic [NUM_CH-1:0]   ch_mask,
`endif
  output logic                convst_n,
  input  logic                adc_busy,
  output logic                rd_start,
  input  logic                rd_busy,
  input  logic [ADC_DW-1:0]   rd_data,
  output logic [ADC_DW-1:0]   ch_data,
  output logic [CH_IDX_W-1:0] ch_idx,
  output logic                ch_valid,
  output logic                frame_done,
  output logic                scan_busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + CONV_PULSE + 1);

  scan_state_t         state, next_state;
  logic [TW-1:0]       tmr;
  logic [CH_IDX_W-1:0] ch_cnt;
  logic                busy_s1, busy_s2;
  logic                rd_seen;
  logic                tick;
  logic                tmo;
  logic                last_ch;
  logic                rd_done;
  logic                ch_en;

  adc_rate_timer #(.CLK_DIV(CLK_DIV)) u_rate_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign last_ch = (ch_cnt == CH_IDX_W'(NUM_CH - 1));
  assign rd_done = (state == WAIT_RD) && rd_seen && !rd_busy;

`ifdef ADC_SCAN_CH_MASK_EN
  logic [7:0] mask_ext;
  assign mask_ext = 8'(ch_mask);
  assign ch_en    = mask_ext[ch_cnt];
`else
  assign ch_en = 1'b1;
`endif

  // Two-flop synchroniser for the asynchronous chip BUSY line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
    end else begin
      busy_s1 <= adc_busy;
      busy_s2 <= busy_s1;
    end
  end

  // Next-state decode; tmo flags a BUSY wait that ran out
  always_comb begin
    next_state = state;
    tmo        = 1'b0;
    case (state)
      IDLE:    if (tick || single_shot) next_state = CONV;
      CONV:    if (tmr == TW'(CONV_PULSE - 1)) next_state = WAIT_BH;
      WAIT_BH: begin
        if (busy_s2) begin
          next_state = WAIT_BL;
        end else if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
          tmo        = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_BL: begin
        if (!busy_s2) begin
          next_state = ISSUE;
        end else if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
          tmo        = 1'b1;
          next_state = IDLE;
        end
      end
      ISSUE:   next_state = WAIT_RD;
      WAIT_RD: if (rd_seen && !rd_busy) next_state = NEXT;
      NEXT:    next_state = last_ch ? IDLE : ISSUE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus phase timer, read handshake tracker and channel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      rd_seen <= 1'b0;
      ch_cnt  <= '0;
    end else begin
      state <= next_state;
      if (state != next_state) begin
        tmr <= '0;
      end else if (state == CONV || state == WAIT_BH || state == WAIT_BL) begin
        tmr <= tmr + TW'(1);
      end
      if (state == ISSUE) begin
        rd_seen <= 1'b0;
      end else if (state == WAIT_RD && rd_busy) begin
        rd_seen <= 1'b1;
      end
      if (tmo) begin
        ch_cnt <= '0;
      end else if (state == NEXT) begin
        ch_cnt <= last_ch ? '0 : ch_cnt + CH_IDX_W'(1);
      end
    end
  end

  // Registered outputs, sticky error flags (a set event beats err_clr)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      convst_n    <= 1'b1;
      rd_start    <= 1'b0;
      scan_busy   <= 1'b0;
      ch_data     <= '0;
      ch_idx      <= '0;
      ch_valid    <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      convst_n   <= (next_state != CONV);
      rd_start   <= (next_state == ISSUE);
      scan_busy  <= (next_state != IDLE);
      frame_done <= (state == NEXT) && last_ch;
      ch_valid   <= 1'b0;
      if (rd_done && ch_en) begin
        ch_data  <= rd_data;
        ch_idx   <= ch_cnt;
        ch_valid <= 1'b1;
      end
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
      if (tmo) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler with a behavioural AD7606
// BUSY model and a behavioural read controller returning 16'h1000+word.
module tb_adc_scan_scheduler;

  localparam int CLK_DIV      = 100;
  localparam int NUM_CH       = 4;
  localparam int CONV_PULSE   = 2;
  localparam int BUSY_TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        single_shot = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  mask = 4'hF;
  logic        convst_n;
  logic        adc_busy = 1'b0;
  logic        rd_start;
  logic        rd_busy = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic [15:0] ch_data;
  logic [2:0]  ch_idx;
  logic        ch_valid, frame_done, scan_busy, overrun, timeout_err;

  adc_scan_scheduler #(
    .CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH),
    .CONV_PULSE(CONV_PULSE), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .err_clr(err_clr),
`ifdef ADC_SCAN_CH_MASK_EN
    .ch_mask(mask),
`endif
    .convst_n(convst_n), .adc_busy(adc_busy), .rd_start(rd_start),
    .rd_busy(rd_busy), .rd_data(rd_data), .ch_data(ch_data), .ch_idx(ch_idx),
    .ch_valid(ch_valid), .frame_done(frame_done), .scan_busy(scan_busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Chip model: BUSY rises 3 cycles after CONVST rises, stays high busy_len cycles
  int  busy_len   = 20;
  bit  chip_stuck = 1'b0;
  int  chip_phase = 0;
  int  chip_cnt   = 0;
  logic chip_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      adc_busy   = 1'b0;
      chip_phase = 0;
    end else if (chip_phase == 0) begin
      if (!chip_prev && convst_n && !chip_stuck) begin
        chip_phase = 1;
        chip_cnt   = 0;
      end
    end else if (chip_phase == 1) begin
      chip_cnt++;
      if (chip_cnt == 3) begin
        adc_busy   = 1'b1;
        chip_phase = 2;
        chip_cnt   = 0;
      end
    end else begin
      chip_cnt++;
      if (chip_cnt >= busy_len) begin
        adc_busy   = 1'b0;
        chip_phase = 0;
      end
    end
    chip_prev = convst_n;
  end

  // Read controller model: busy for rd_lat cycles, then presents 16'h1000+word
  int rd_lat   = 3;
  int rd_phase = 0;
  int rd_cnt   = 0;
  int rd_word  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_busy  = 1'b0;
      rd_phase = 0;
      rd_word  = 0;
    end else begin
      if (!convst_n) rd_word = 0;
      if (rd_phase == 0) begin
        if (rd_start) begin
          rd_phase = 1;
          rd_cnt   = 0;
        end
      end else begin
        rd_cnt++;
        if (rd_cnt == 1) rd_busy = 1'b1;
        if (rd_cnt == 1 + rd_lat) begin
          rd_data  = 16'h1000 + 16'(rd_word);
          rd_busy  = 1'b0;
          rd_word++;
          rd_phase = 0;
        end
      end
    end
  end

  // Output monitor: event counters and per-strobe idx/data checks
  int   n_valid = 0, n_done = 0, n_fall = 0, n_rd = 0;
  int   fall_cyc [4];
  int   rise_cyc = 0, err_cyc = 0, mon_ptr = 0;
  logic conv_prev = 1'b1, err_prev = 1'b0;

  always @(negedge clk) begin
    if (conv_prev && !convst_n) begin
      mon_ptr = 0;
      if (n_fall < 4) fall_cyc[n_fall] = cyc - base;
      n_fall++;
    end
    if (!conv_prev && convst_n) rise_cyc = cyc;
    if (timeout_err && !err_prev) err_cyc = cyc;
    if (rd_start) n_rd++;
    if (frame_done) n_done++;
    if (ch_valid) begin
      while (mon_ptr < NUM_CH && mask[2'(mon_ptr)] == 1'b0) mon_ptr++;
      checkOutput("ch_idx", 32'(ch_idx), 32'(mon_ptr));
      checkOutput("ch_data", 32'(ch_data), 32'h1000 + 32'(mon_ptr));
      mon_ptr++;
      n_valid++;
    end
    conv_prev = convst_n;
    err_prev  = timeout_err;
  end

  typedef struct {
    int busy_len;
    int rd_lat;
    bit stuck;
    int exp_valid;
    int exp_done;
    int exp_rd;
    bit exp_tout;
  } vec_t;

  vec_t vecs [5];

  task automatic tickCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearCounters();
    n_valid = 0; n_done = 0; n_fall = 0; n_rd = 0;
  endtask

  task automatic applyStimulus(input int blen, input int rlat, input bit stuck);
    busy_len   = blen;
    rd_lat     = rlat;
    chip_stuck = stuck;
    tickCycles(1);
    err_clr = 1'b1;
    clearCounters();
    tickCycles(1);
    err_clr     = 1'b0;
    single_shot = 1'b1;
    tickCycles(1);
    single_shot = 1'b0;
  endtask

  initial begin
    bit found;
    vecs[0] = '{20, 3, 1'b0, 4, 1, 4, 1'b0};
    vecs[1] = '{5,  1, 1'b0, 4, 1, 4, 1'b0};
    vecs[2] = '{60, 8, 1'b0, 4, 1, 4, 1'b0};
    vecs[3] = '{0,  3, 1'b1, 0, 0, 0, 1'b1};
    vecs[4] = '{20, 2, 1'b0, 4, 1, 4, 1'b0};

    // Reset values
    tickCycles(3);
    checkOutput("rst_convst_n", 32'(convst_n), 1);
    checkOutput("rst_scan_busy", 32'(scan_busy), 0);
    checkOutput("rst_ch_valid", 32'(ch_valid), 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tickCycles(2);

    // Periodic scanning: first CONVST at cycle 100, next frame at 200
    $display("[TB] periodic scan");
    clearCounters();
    base   = cyc;
    enable = 1'b1;
    tickCycles(190);
    checkOutput("p_first_fall", 32'(fall_cyc[0]), 100);
    checkOutput("p_convst_width", 32'(rise_cyc - base - fall_cyc[0]), 2);
    checkOutput("p_valid_cnt", 32'(n_valid), 4);
    checkOutput("p_done_cnt", 32'(n_done), 1);
    checkOutput("p_fall_cnt", 32'(n_fall), 1);
    tickCycles(15);
    checkOutput("p_second_fall", 32'(fall_cyc[1]), 200);
    enable = 1'b0;
    tickCycles(200);
    checkOutput("p_valid_cnt2", 32'(n_valid), 8);
    checkOutput("p_done_cnt2", 32'(n_done), 2);
    checkOutput("p_no_more_conv", 32'(n_fall), 2);
    checkOutput("p_overrun", 32'(overrun), 0);

    // Single-shot frames from the vector table (enable low)
    $display("[TB] single-shot table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].busy_len, vecs[i].rd_lat, vecs[i].stuck);
      tickCycles(400);
      checkOutput("v_valid_cnt", 32'(n_valid), 32'(vecs[i].exp_valid));
      checkOutput("v_done_cnt", 32'(n_done), 32'(vecs[i].exp_done));
      checkOutput("v_rd_cnt", 32'(n_rd), 32'(vecs[i].exp_rd));
      checkOutput("v_conv_cnt", 32'(n_fall), 1);
      checkOutput("v_timeout_err", 32'(timeout_err), 32'(vecs[i].exp_tout));
      checkOutput("v_idle", 32'(scan_busy), 0);
      if (vecs[i].stuck) checkOutput("v_timeout_lat", 32'(err_cyc - rise_cyc), 32'(BUSY_TIMEOUT));
    end

    // Overrun: BUSY stretched past the next tick
    $display("[TB] overrun");
    busy_len = 150;
    rd_lat   = 3;
    clearCounters();
    tickCycles(1);
    base   = cyc;
    enable = 1'b1;
    tickCycles(199);
    checkOutput("o_before_tick", 32'(overrun), 0);
    tickCycles(2);
    checkOutput("o_after_tick", 32'(overrun), 1);
    enable = 1'b0;
    tickCycles(300);
    checkOutput("o_valid_cnt", 32'(n_valid), 4);
    checkOutput("o_done_cnt", 32'(n_done), 1);
    checkOutput("o_sticky", 32'(overrun), 1);
    err_clr = 1'b1;
    tickCycles(1);
    err_clr = 1'b0;
    checkOutput("o_cleared", 32'(overrun), 0);

    // Reset during WAIT_RD of channel 2
    $display("[TB] reset mid-frame");
    applyStimulus(20, 6, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      tickCycles(1);
      if (rd_word == 2 && rd_busy) found = 1'b1;
    end
    checkOutput("r_reached_ch2", 32'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("r_convst_n", 32'(convst_n), 1);
    checkOutput("r_scan_busy", 32'(scan_busy), 0);
    checkOutput("r_ch_data", 32'(ch_data), 0);
    checkOutput("r_ch_idx", 32'(ch_idx), 0);
    checkOutput("r_rd_start", 32'(rd_start), 0);
    tickCycles(2);
    rst_n = 1'b1;
    applyStimulus(20, 3, 1'b0);
    tickCycles(300);
    checkOutput("r_valid_cnt", 32'(n_valid), 4);
    checkOutput("r_done_cnt", 32'(n_done), 1);

`ifdef ADC_SCAN_CH_MASK_EN
    // Channel mask: only idx 0 and 2 strobe, all four still read
    $display("[TB] channel mask");
    mask = 4'b0101;
    applyStimulus(20, 3, 1'b0);
    tickCycles(300);
    checkOutput("m_valid_cnt", 32'(n_valid), 2);
    checkOutput("m_rd_cnt", 32'(n_rd), 4);
    checkOutput("m_done_cnt", 32'(n_done), 1);
    mask = 4'hF;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
